// File: rtl/imem_ctrl_pkg.sv
// Shared types and helpers for the instruction-memory access controller.
// Holds the FSM state encoding, the requester identity and the word geometry.
package imem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      DONE   = 2'd3
   } state_t;

   typedef enum logic {
      REQ_FETCH = 1'b0,
      REQ_LOAD  = 1'b1
   } req_t;

   localparam int WORD_BYTES = 4;

   // Word-aligned and the whole word inside the memory; 33-bit sum so a
   // wrap-around near 0xFFFF_FFFF cannot look legal.
   function automatic logic access_legal(input logic [31:0] addr,
                                         input int unsigned mem_bytes);
      logic [32:0] last_byte;
      last_byte = {1'b0, addr} + 33'(WORD_BYTES - 1);
      return (addr[1:0] == 2'b00) && (last_byte < 33'(mem_bytes));
   endfunction

endpackage

// File: rtl/imem_arb_pick.sv
// Loader-first arbiter with a starvation counter that forces a waiting
// fetch through after STARVE_LIMIT back-to-back loader grants.
module imem_arb_pick
   import imem_ctrl_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic arb_en,
   input  logic fetch_req,
   input  logic load_req,
   output logic grant_valid,
   output req_t grant_who
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_reg;
   logic [CNT_W-1:0] starve_cnt_next;
   logic             force_fetch;

   assign force_fetch = fetch_req && (starve_cnt_reg == CNT_MAX);

   always_comb begin
      grant_valid = arb_en && (fetch_req || load_req);
      grant_who   = (load_req && !force_fetch) ? REQ_LOAD : REQ_FETCH;
   end

   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (!fetch_req) begin
         starve_cnt_next = '0;
      end else if (grant_valid) begin
         if (grant_who == REQ_FETCH) begin
            starve_cnt_next = '0;
         end else if (starve_cnt_reg != CNT_MAX) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_reg <= '0;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
      end
   end

endmodule

// File: rtl/imem_access_ctrl.sv
// Shares one strobe-driven instruction memory between fetch (read) and the
// program loader (write): address setup, one-cycle strobe, then a response.
module imem_access_ctrl
   import imem_ctrl_pkg::*;
#(
   parameter int MEM_BYTES    = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   output logic        fetch_ack,
   output logic        fetch_valid,
   output logic [31:0] fetch_data,
   output logic        fetch_err,
   input  logic        load_req,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   output logic        load_ack,
   output logic        load_done,
   output logic        load_err,
   output logic [31:0] inst_address,
   output logic [31:0] inst_write_data,
   output logic        inst_read,
   output logic        inst_write,
   input  logic [31:0] inst_rdata,
   output logic        busy
);

   state_t      state_reg, state_next;
   req_t        who_reg, who_next;
   req_t        err_who_reg, err_who_next;
   logic        err_pend_reg, err_pend_next;
   logic [31:0] addr_reg, addr_next;
   logic [31:0] wdata_reg, wdata_next;
   logic [31:0] fetch_data_reg, fetch_data_next;
   logic        rd_stb_reg, rd_stb_next;
   logic        wr_stb_reg, wr_stb_next;
   logic        fetch_ack_reg, fetch_ack_next;
   logic        load_ack_reg, load_ack_next;
   logic        fetch_valid_reg, fetch_valid_next;
   logic        fetch_err_reg, fetch_err_next;
   logic        load_done_reg, load_done_next;
   logic        load_err_reg, load_err_next;

   logic        arb_en;
   logic        fetch_req_eff;
   logic        load_req_eff;
   logic        grant_valid;
   req_t        grant_who;
   logic [31:0] grant_addr;
   logic        grant_legal;

   // A requester whose ack is showing is retiring its request on this edge;
   // hide it so an illegal grant resolved in DONE is not granted twice.
   assign arb_en        = (state_reg == IDLE) || (state_reg == DONE);
   assign fetch_req_eff = fetch_req && !fetch_ack_reg;
   assign load_req_eff  = load_req && !load_ack_reg;

   imem_arb_pick #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .arb_en     (arb_en),
      .fetch_req  (fetch_req_eff),
      .load_req   (load_req_eff),
      .grant_valid(grant_valid),
      .grant_who  (grant_who)
   );

   assign grant_addr  = (grant_who == REQ_LOAD) ? load_addr : fetch_addr;
   assign grant_legal = access_legal(grant_addr, MEM_BYTES);

   always_comb begin
      state_next       = state_reg;
      who_next         = who_reg;
      err_who_next     = err_who_reg;
      err_pend_next    = 1'b0;
      addr_next        = addr_reg;
      wdata_next       = wdata_reg;
      fetch_data_next  = fetch_data_reg;
      rd_stb_next      = 1'b0;
      wr_stb_next      = 1'b0;
      fetch_ack_next   = 1'b0;
      load_ack_next    = 1'b0;
      fetch_valid_next = 1'b0;
      fetch_err_next   = 1'b0;
      load_done_next   = 1'b0;
      load_err_next    = 1'b0;

      // An illegal grant answers one cycle after its ack, independent of
      // whatever the FSM does next.
      if (err_pend_reg) begin
         if (err_who_reg == REQ_FETCH) begin
            fetch_valid_next = 1'b1;
            fetch_err_next   = 1'b1;
         end else begin
            load_done_next = 1'b1;
            load_err_next  = 1'b1;
         end
      end

      unique case (state_reg)
         IDLE, DONE: begin
            state_next = IDLE;
            if (grant_valid) begin
               who_next = grant_who;
               if (grant_who == REQ_FETCH) begin
                  fetch_ack_next = 1'b1;
               end else begin
                  load_ack_next = 1'b1;
               end
               if (grant_legal) begin
                  addr_next = grant_addr;
                  if (grant_who == REQ_LOAD) begin
                     wdata_next = load_data;
                  end
                  state_next = SETUP;
               end else begin
                  err_pend_next = 1'b1;
                  err_who_next  = grant_who;
                  state_next    = DONE;
               end
            end
         end
         SETUP: begin
            if (who_reg == REQ_FETCH) begin
               rd_stb_next = 1'b1;
            end else begin
               wr_stb_next = 1'b1;
            end
            state_next = STROBE;
         end
         STROBE: begin
            state_next = DONE;
            if (who_reg == REQ_FETCH) begin
               fetch_valid_next = 1'b1;
               fetch_data_next  = inst_rdata;
            end else begin
               load_done_next = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         who_reg         <= REQ_FETCH;
         err_who_reg     <= REQ_FETCH;
         err_pend_reg    <= 1'b0;
         addr_reg        <= '0;
         wdata_reg       <= '0;
         fetch_data_reg  <= '0;
         rd_stb_reg      <= 1'b0;
         wr_stb_reg      <= 1'b0;
         fetch_ack_reg   <= 1'b0;
         load_ack_reg    <= 1'b0;
         fetch_valid_reg <= 1'b0;
         fetch_err_reg   <= 1'b0;
         load_done_reg   <= 1'b0;
         load_err_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         who_reg         <= who_next;
         err_who_reg     <= err_who_next;
         err_pend_reg    <= err_pend_next;
         addr_reg        <= addr_next;
         wdata_reg       <= wdata_next;
         fetch_data_reg  <= fetch_data_next;
         rd_stb_reg      <= rd_stb_next;
         wr_stb_reg      <= wr_stb_next;
         fetch_ack_reg   <= fetch_ack_next;
         load_ack_reg    <= load_ack_next;
         fetch_valid_reg <= fetch_valid_next;
         fetch_err_reg   <= fetch_err_next;
         load_done_reg   <= load_done_next;
         load_err_reg    <= load_err_next;
      end
   end

   assign fetch_ack       = fetch_ack_reg;
   assign fetch_valid     = fetch_valid_reg;
   assign fetch_data      = fetch_data_reg;
   assign fetch_err       = fetch_err_reg;
   assign load_ack        = load_ack_reg;
   assign load_done       = load_done_reg;
   assign load_err        = load_err_reg;
   assign inst_address    = addr_reg;
   assign inst_write_data = wdata_reg;
   assign inst_read       = rd_stb_reg;
   assign inst_write      = wr_stb_reg;
   assign busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Self-checking bench: directed vector table, arbitration/reset sequences and
// random accesses scored against a byte-array model of the memory.
module tb_imem_access_ctrl;

   localparam int MEM_BYTES = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_req = 1'b0;
   logic [31:0] fetch_addr = '0;
   logic        fetch_ack, fetch_valid, fetch_err;
   logic [31:0] fetch_data;
   logic        load_req = 1'b0;
   logic [31:0] load_addr = '0;
   logic [31:0] load_data = '0;
   logic        load_ack, load_done, load_err;
   logic [31:0] inst_address, inst_write_data, inst_rdata;
   logic        inst_read, inst_write, busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [MEM_BYTES];      // memory seen by the DUT
   logic [7:0] ref_mem [MEM_BYTES];  // reference model contents

   always #5 clk = ~clk;

   imem_access_ctrl #(.MEM_BYTES(MEM_BYTES), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
      .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
      .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
      .load_ack(load_ack), .load_done(load_done), .load_err(load_err),
      .inst_address(inst_address), .inst_write_data(inst_write_data),
      .inst_read(inst_read), .inst_write(inst_write), .inst_rdata(inst_rdata),
      .busy(busy)
   );

   // Big-endian memory that reads combinationally and writes on a strobe rise.
   always_comb begin
      inst_rdata = '0;
      if (inst_address <= 32'(MEM_BYTES - 4))
         inst_rdata = {mem[inst_address[4:0]], mem[inst_address[4:0] + 5'd1],
                       mem[inst_address[4:0] + 5'd2], mem[inst_address[4:0] + 5'd3]};
   end

   always @(posedge inst_write) begin
      if (inst_address <= 32'(MEM_BYTES - 4)) begin
         mem[inst_address[4:0]]        = inst_write_data[31:24];
         mem[inst_address[4:0] + 5'd1] = inst_write_data[23:16];
         mem[inst_address[4:0] + 5'd2] = inst_write_data[15:8];
         mem[inst_address[4:0] + 5'd3] = inst_write_data[7:0];
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (inst_read && inst_write) begin
            errors++;
            $display("FAIL both_strobes: read=%0b write=%0b required not both 1", inst_read, inst_write);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic bit model_legal(input logic [31:0] a);
      return (a % 4 == 0) && (64'(a) + 64'd3 < 64'(MEM_BYTES));
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      return {ref_mem[a], ref_mem[a + 1], ref_mem[a + 2], ref_mem[a + 3]};
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d);
      for (int b = 0; b < 4; b++) ref_mem[a + b] = d[31 - 8*b -: 8];
   endtask

   // One access by a single requester; reports response timing relative to ack.
   task automatic access(input bit is_load, input logic [31:0] addr, input logic [31:0] data,
                         output bit acked, output bit got_err, output logic [31:0] got_data,
                         output int resp_k, output int stb_k, output int nstb, output int wrong_stb);
      acked = 0; got_err = 0; got_data = '0; resp_k = -1; stb_k = -1; nstb = 0; wrong_stb = 0;
      @(negedge clk);
      if (is_load) begin
         load_req = 1; load_addr = addr; load_data = data;
      end else begin
         fetch_req = 1; fetch_addr = addr;
      end
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (is_load ? load_ack : fetch_ack) begin
            acked = 1;
            break;
         end
      end
      fetch_req = 0; load_req = 0;
      if (!acked) return;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (inst_read || inst_write) begin
            nstb++;
            if (stb_k < 0) stb_k = k;
         end
         if (is_load ? inst_read : inst_write) wrong_stb++;
         if (resp_k < 0 && (is_load ? load_done : fetch_valid)) begin
            resp_k   = k;
            got_err  = is_load ? load_err : fetch_err;
            got_data = fetch_data;
         end
      end
   endtask

   task automatic run_and_check(input string tag, input bit is_load, input logic [31:0] addr,
                                input logic [31:0] data, input bit exp_err,
                                input logic [31:0] exp_data);
      bit acked, got_err;
      logic [31:0] got_data;
      int resp_k, stb_k, nstb, wrong_stb;
      access(is_load, addr, data, acked, got_err, got_data, resp_k, stb_k, nstb, wrong_stb);
      chk({tag, " ack"}, 32'(acked), 32'd1);
      chk({tag, " err"}, 32'(got_err), 32'(exp_err));
      chk({tag, " resp_latency"}, 32'(resp_k), exp_err ? 32'd1 : 32'd2);
      chk({tag, " strobe_count"}, 32'(nstb), exp_err ? 32'd0 : 32'd1);
      chk({tag, " wrong_strobe"}, 32'(wrong_stb), 32'd0);
      if (!exp_err) chk({tag, " strobe_cycle"}, 32'(stb_k), 32'd1);
      if (!is_load && !exp_err) chk({tag, " data"}, got_data, exp_data);
      if (is_load && !exp_err) model_write(addr, data);
   endtask

   typedef struct {
      bit          is_load;
      logic [31:0] addr;
      logic [31:0] data;
      bit          exp_err;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int gap, last_grant, ngrant;
      bit saw_valid;

      vecs[0]  = '{0, 32'h0000_0000, 32'h0,         0, 32'he081_5002};
      vecs[1]  = '{1, 32'h0000_0010, 32'h1122_3344, 0, 32'h0};
      vecs[2]  = '{0, 32'h0000_0010, 32'h0,         0, 32'h1122_3344};
      vecs[3]  = '{0, 32'h0000_0002, 32'h0,         1, 32'h0};
      vecs[4]  = '{0, 32'h0000_0020, 32'h0,         1, 32'h0};
      vecs[5]  = '{1, 32'h0000_001C, 32'hdead_beef, 0, 32'h0};
      vecs[6]  = '{1, 32'h0000_001E, 32'h0123_4567, 1, 32'h0};
      vecs[7]  = '{0, 32'h0000_001C, 32'h0,         0, 32'hdead_beef};
      vecs[8]  = '{0, 32'h0000_001D, 32'h0,         1, 32'h0};
      vecs[9]  = '{1, 32'hFFFF_FFFC, 32'hcafe_f00d, 1, 32'h0};
      vecs[10] = '{0, 32'h0000_0004, 32'h0,         0, 32'h0000_0000};

      for (int i = 0; i < MEM_BYTES; i++) begin
         mem[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      mem[0] = 8'he0; mem[1] = 8'h81; mem[2] = 8'h50; mem[3] = 8'h02;
      ref_mem[0] = 8'he0; ref_mem[1] = 8'h81; ref_mem[2] = 8'h50; ref_mem[3] = 8'h02;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst strobes", {30'd0, inst_read, inst_write}, 32'd0);
      chk("rst pulses", {26'd0, fetch_ack, fetch_valid, fetch_err, load_ack, load_done, load_err}, 32'd0);
      chk("rst fetch_data", fetch_data, 32'd0);
      chk("rst inst_address", inst_address, 32'd0);
      chk("rst inst_write_data", inst_write_data, 32'd0);
      rst_n = 1;
      $display("reset released");

      for (int i = 0; i < 11; i++) begin
         run_and_check($sformatf("vec%0d", i), vecs[i].is_load, vecs[i].addr, vecs[i].data,
                       vecs[i].exp_err, vecs[i].exp_data);
         $display("vec %0d: %s addr=%h data=%h exp_err=%0b", i, vecs[i].is_load ? "load " : "fetch",
                  vecs[i].addr, vecs[i].data, vecs[i].exp_err);
      end

      // Both requests held: expect L L L L F repeating, one grant every 3 cycles.
      @(negedge clk);
      fetch_addr = 32'h0; load_addr = 32'h8; load_data = 32'h5a5a_0ff0;
      fetch_req = 1; load_req = 1;
      ngrant = 0; last_grant = -1;
      for (int c = 0; c < 60 && ngrant < 15; c++) begin
         @(negedge clk);
         if (fetch_ack || load_ack) begin
            chk($sformatf("starve grant%0d kind", ngrant), 32'(fetch_ack), (ngrant % 5 == 4) ? 32'd1 : 32'd0);
            if (last_grant >= 0) begin
               gap = c - last_grant;
               chk($sformatf("starve grant%0d gap", ngrant), 32'(gap), 32'd3);
            end
            $display("grant %0d: %s at cycle %0d", ngrant, fetch_ack ? "fetch" : "load", c);
            last_grant = c;
            ngrant++;
         end
      end
      chk("starve grants seen", 32'(ngrant), 32'd15);
      fetch_req = 0; load_req = 0;
      model_write(32'h8, 32'h5a5a_0ff0);
      repeat (6) @(negedge clk);
      chk("starve idle after", 32'(busy), 32'd0);

      // Reset while the fetch strobe is high.
      fetch_addr = 32'h10; fetch_req = 1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (fetch_ack) break;
      end
      fetch_req = 0;
      @(negedge clk);
      chk("rstmid read_high", 32'(inst_read), 32'd1);
      #2 rst_n = 0;
      #1;
      chk("rstmid read_drop", 32'(inst_read), 32'd0);
      chk("rstmid busy", 32'(busy), 32'd0);
      saw_valid = 0;
      @(negedge clk);
      if (fetch_valid) saw_valid = 1;
      rst_n = 1;
      repeat (3) begin
         @(negedge clk);
         if (fetch_valid) saw_valid = 1;
      end
      chk("rstmid no_valid", 32'(saw_valid), 32'd0);
      $display("reset mid-strobe done");
      run_and_check("post_rst", 0, 32'h10, 32'h0, 0, model_read(32'h10));

      // Random accesses against the byte-array model.
      for (int n = 0; n < 40; n++) begin
         bit ld;
         logic [31:0] a, d;
         ld = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0, 1: a = 32'($urandom_range(0, 7) * 4);
            2:    a = 32'($urandom_range(0, 40));
            default: a = $urandom;
         endcase
         d = $urandom;
         run_and_check($sformatf("rnd%0d", n), ld, a, d, !model_legal(a),
                       model_legal(a) ? model_read(a) : 32'h0);
         $display("rnd %0d: %s addr=%h data=%h", n, ld ? "load " : "fetch", a, d);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
